// File: rtl/matrix_transpose_stream.sv
// Streams N rows of an N x N matrix into a single buffer, then emits N vectors:
// its columns (mode 0) or its rows unchanged (mode 1). Loading and draining alternate.
module matrix_transpose_stream #(
  parameter int N = 5,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_row,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_col,
  output logic           out_last,
  output logic           busy
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {LOAD, DRAIN} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] rcnt, ocnt;
  logic          mode_q;
  logic [W-1:0]  mem [N][N];
  logic          in_xfer, out_xfer;

  // Handshakes are gated by rst so nothing transfers while reset is held.
  assign in_ready  = !rst && (state == LOAD);
  assign out_valid = !rst && (state == DRAIN);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign out_last  = (state == DRAIN) && (ocnt == LAST);
  assign busy      = (state != LOAD) || (rcnt != '0);

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_xfer && rcnt == LAST)   state_nxt = DRAIN;
      DRAIN:   if (out_xfer && ocnt == LAST)  state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt   <= '0;
      ocnt   <= '0;
      mode_q <= 1'b0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          mem[r][c] <= '0;
    end else begin
      if (in_xfer) begin
        for (int k = 0; k < N; k++)
          mem[rcnt][k] <= in_row[(N-k)*W-1 -: W];
        // Mode is captured once per matrix, on its first row.
        if (rcnt == '0)
          mode_q <= mode;
        if (rcnt == LAST) begin
          rcnt <= '0;
          ocnt <= '0;
        end else begin
          rcnt <= rcnt + 1'b1;
        end
      end
      if (out_xfer)
        ocnt <= (ocnt == LAST) ? '0 : ocnt + 1'b1;
    end
  end

  always_comb begin
    out_col = '0;
    if (out_valid)
      for (int r = 0; r < N; r++)
        out_col[(N-r)*W-1 -: W] = mode_q ? mem[ocnt][r] : mem[r][ocnt];
  end

endmodule
